// File: rtl/axi_slave_ram_if.sv
// AXI4 bus bundle between a master and the on-chip RAM responder.
// The slave modport is the responder view; the master modport is the requester view.
interface axi_slave_ram_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_brust;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_brust;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic                    r_valid;
  logic                    r_ready;

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_brust, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_brust, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_brust, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_brust, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );
endinterface

// File: rtl/axi_slave_ram.sv
// AXI4 responder backed by an on-chip word array; independent write and read engines.
// Define AXI_SLV_BP_EN to add LFSR-driven backpressure on W and gaps on R.
module axi_slave_ram #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic           axi_clk,
  input  logic           axi_rst,
  axi_slave_ram_if.slave s_axi
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int TOP    = LSB + MEM_DEPTH_LOG2;
  localparam int DEPTH  = 2 ** MEM_DEPTH_LOG2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic [1:0] classify(input logic [ADDR_WIDTH-TOP-1:0] hi,
                                          input logic [1:0] burst,
                                          input logic [2:0] size);
    if (hi != '0) return RESP_DECERR;
    if (burst[1] || size != 3'(LSB)) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic idx_t advance(input idx_t idx, input logic fixed);
    return fixed ? idx : idx + idx_t'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte lanes below the word index never select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.aw_addr[LSB-1:0], s_axi.ar_addr[LSB-1:0]};

  logic w_gate, r_hold;
`ifdef AXI_SLV_BP_EN
  logic [15:0] lfsr;
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign w_gate = lfsr[0];
  assign r_hold = lfsr[1];
`else
  assign w_gate = 1'b0;
  assign r_hold = 1'b0;
`endif

  // ---------------- write engine ----------------
  w_state_t              w_state, w_state_nx;
  logic [ID_WIDTH-1:0]   w_id;
  idx_t                  w_idx;
  logic [7:0]            w_len, w_cnt;
  logic [1:0]            w_err;
  logic                  w_fixed;
  logic [ID_WIDTH-1:0]   b_id_q;
  logic [1:0]            b_resp_q;
  logic                  aw_fire, w_fire, w_cnt_last, w_end;

  assign s_axi.aw_ready = (w_state == W_IDLE);
  assign s_axi.w_ready  = (w_state == W_DATA) && !w_gate;
  assign s_axi.b_valid  = (w_state == W_RESP);
  assign s_axi.b_id     = b_id_q;
  assign s_axi.b_resp   = b_resp_q;

  assign aw_fire    = s_axi.aw_valid && (w_state == W_IDLE);
  assign w_fire     = s_axi.w_valid && (w_state == W_DATA) && !w_gate;
  assign w_cnt_last = (w_cnt == w_len);
  assign w_end      = w_cnt_last || s_axi.w_last;

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) w_state <= W_IDLE;
    else         w_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = w_state;
    unique case (w_state)
      W_IDLE:  if (s_axi.aw_valid) w_state_nx = W_DATA;
      W_DATA:  if (w_fire && w_end) w_state_nx = W_RESP;
      W_RESP:  if (s_axi.b_ready) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (aw_fire) begin
      w_id    <= s_axi.aw_id;
      w_idx   <= s_axi.aw_addr[LSB +: MEM_DEPTH_LOG2];
      w_len   <= s_axi.aw_len;
      w_cnt   <= 8'd0;
      w_err   <= classify(s_axi.aw_addr[ADDR_WIDTH-1:TOP], s_axi.aw_brust, s_axi.aw_size);
      w_fixed <= (s_axi.aw_brust == 2'b00);
    end else if (w_fire) begin
      w_cnt <= w_cnt + 8'd1;
      w_idx <= advance(w_idx, w_fixed);
    end
  end

  // A latched address error outranks a w_last/length disagreement.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      b_id_q   <= '0;
      b_resp_q <= RESP_OKAY;
    end else if (w_fire && w_end) begin
      b_id_q   <= w_id;
      b_resp_q <= (w_err != RESP_OKAY)            ? w_err :
                  (s_axi.w_last != w_cnt_last)     ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (w_fire && w_err == RESP_OKAY) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.w_strb[b]) mem[w_idx][b*8 +: 8] <= s_axi.w_data[b*8 +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_t              r_state, r_state_nx;
  idx_t                  r_idx, r_next_idx, ar_idx;
  logic [7:0]            r_len, r_cnt;
  logic                  r_fixed;
  logic [1:0]            ar_err;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [1:0]            r_resp_q;
  logic                  r_last_q, r_valid_q;
  logic                  ar_fire, r_fire;

  assign s_axi.ar_ready = (r_state == R_IDLE);
  assign s_axi.r_id     = r_id_q;
  assign s_axi.r_data   = r_data_q;
  assign s_axi.r_resp   = r_resp_q;
  assign s_axi.r_last   = r_last_q;
  assign s_axi.r_valid  = r_valid_q;

  assign ar_fire    = s_axi.ar_valid && (r_state == R_IDLE);
  assign r_fire     = r_valid_q && s_axi.r_ready;
  assign ar_idx     = s_axi.ar_addr[LSB +: MEM_DEPTH_LOG2];
  assign ar_err     = classify(s_axi.ar_addr[ADDR_WIDTH-1:TOP], s_axi.ar_brust, s_axi.ar_size);
  assign r_next_idx = advance(r_idx, r_fixed);

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) r_state <= R_IDLE;
    else         r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx = r_state;
    unique case (r_state)
      R_IDLE:  if (s_axi.ar_valid) r_state_nx = R_DATA;
      R_DATA:  if (r_fire && r_last_q) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (ar_fire) begin
      r_idx   <= ar_idx;
      r_len   <= s_axi.ar_len;
      r_cnt   <= 8'd0;
      r_fixed <= (s_axi.ar_brust == 2'b00);
    end else if (r_fire && !r_last_q) begin
      r_idx <= r_next_idx;
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // The next word is fetched on the accepting edge so consecutive beats have no bubble.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_id_q    <= '0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
      r_last_q  <= 1'b0;
      r_valid_q <= 1'b0;
    end else if (ar_fire) begin
      r_id_q    <= s_axi.ar_id;
      r_resp_q  <= ar_err;
      r_data_q  <= (ar_err != RESP_OKAY) ? '0 : mem[ar_idx];
      r_last_q  <= (s_axi.ar_len == 8'd0);
      r_valid_q <= !r_hold;
    end else if (r_state == R_DATA) begin
      if (r_fire) begin
        if (r_last_q) begin
          r_valid_q <= 1'b0;
        end else begin
          r_data_q  <= (r_resp_q != RESP_OKAY) ? '0 : mem[r_next_idx];
          r_last_q  <= (r_cnt + 8'd1 == r_len);
          r_valid_q <= !r_hold;
        end
      end else if (!r_valid_q && !r_hold) begin
        r_valid_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed bench for axi_slave_ram: expected B/R responses are queued at issue time
// and a negedge monitor compares them against what the responder presents.
module tb_axi_slave_ram;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_slave_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  axi_slave_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_DEPTH_LOG2(10)) dut (
    .axi_clk(clk),
    .axi_rst(rst),
    .s_axi  (bus)
  );

  typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t exp_b[$];
  r_exp_t exp_r[$];
  b_exp_t eb;
  r_exp_t er;
  int n_cmp = 0;
  int n_fail = 0;

  logic mon_en = 1'b1;
  logic rr_toggle = 1'b0;
  logic rr_level = 1'b1;
  logic tgl = 1'b0;
  always @(posedge clk) tgl <= ~tgl;
  assign bus.r_ready = rr_toggle ? tgl : rr_level;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever a B or R beat is accepted.
  logic          stall_p = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.b_valid && bus.b_ready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          eb = exp_b.pop_front();
          chk("b_id", DW'(bus.b_id), DW'(eb.id));
          chk("b_resp", DW'(bus.b_resp), DW'(eb.resp));
        end
      end
      if (bus.r_valid && bus.r_ready) begin
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          er = exp_r.pop_front();
          chk("r_id", DW'(bus.r_id), DW'(er.id));
          chk("r_data", bus.r_data, er.data);
          chk("r_resp", DW'(bus.r_resp), DW'(er.resp));
          chk("r_last", DW'(bus.r_last), DW'(er.last));
        end
      end
      if (stall_p) begin
        chk("r_stall_valid", DW'(bus.r_valid), 1);
        chk("r_stall_data", bus.r_data, stall_data);
        chk("r_stall_last", DW'(bus.r_last), DW'(stall_last));
      end
      stall_p    <= bus.r_valid && !bus.r_ready;
      stall_data <= bus.r_data;
      stall_last <= bus.r_last;
    end else begin
      stall_p <= 1'b0;
    end
  end

  function automatic logic ready_of(input int which);
    case (which)
      0:       return bus.aw_ready;
      1:       return bus.w_ready;
      default: return bus.ar_ready;
    endcase
  endfunction

  // Entered at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic wait_hs(input int which, input string name);
    int n = 0;
    @(negedge clk);
    while (!ready_of(which) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk({name, "_timeout"}, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input int last_at, input logic [DW-1:0] base, input logic [DW-1:0] step,
                          input logic [7:0] strb, input logic [1:0] resp);
    b_exp_t e;
    e.id = id;
    e.resp = resp;
    exp_b.push_back(e);
    bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len;
    bus.aw_size = size; bus.aw_brust = burst; bus.aw_valid = 1'b1;
    wait_hs(0, "aw");
    bus.aw_valid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.w_data  = base + step * DW'(i);
      bus.w_strb  = strb;
      bus.w_last  = (i == last_at);
      bus.w_valid = 1'b1;
      wait_hs(1, "w");
    end
    bus.w_valid = 1'b0;
    bus.w_last  = 1'b0;
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [DW-1:0] base, input logic [DW-1:0] step, input logic [1:0] resp);
    r_exp_t e;
    for (int i = 0; i <= int'(len); i++) begin
      e.id = id;
      e.data = base + step * DW'(i);
      e.resp = resp;
      e.last = (i == int'(len));
      exp_r.push_back(e);
    end
    bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len;
    bus.ar_size = size; bus.ar_brust = burst; bus.ar_valid = 1'b1;
    wait_hs(2, "ar");
    bus.ar_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) begin
      chk("drain_timeout", 0, 1);
      exp_b.delete();
      exp_r.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_brust = '0;
    bus.aw_valid = 1'b0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_valid = 1'b0;
    bus.b_ready = 1'b1;
    bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_brust = '0;
    bus.ar_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_aw_ready", DW'(bus.aw_ready), 1);
    chk("rst_ar_ready", DW'(bus.ar_ready), 1);
    chk("rst_w_ready", DW'(bus.w_ready), 0);
    chk("rst_b_valid", DW'(bus.b_valid), 0);
    chk("rst_r_valid", DW'(bus.r_valid), 0);
    chk("rst_r_last", DW'(bus.r_last), 0);
    chk("rst_r_data", bus.r_data, 0);
    chk("rst_b_id_resp", DW'({bus.b_id, bus.b_resp}), 0);
    chk("rst_r_id_resp", DW'({bus.r_id, bus.r_resp}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // INCR write/read round trip
    do_write(4'h5, 32'h100, 8'd3, 3'd3, 2'b01, 4, 3, 64'h11, 64'h11, 8'hFF, OKAY);
    drain();
    do_read(4'h5, 32'h100, 8'd3, 3'd3, 2'b01, 64'h11, 64'h11, OKAY);
    drain();

    // Partial strobe merge
    do_write(4'h1, 32'h200, 8'd0, 3'd3, 2'b01, 1, 0, 64'h0123_4567_89AB_CDEF, 64'h0, 8'hFF, OKAY);
    do_write(4'h2, 32'h200, 8'd0, 3'd3, 2'b01, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'h0F, OKAY);
    drain();
    do_read(4'h2, 32'h200, 8'd0, 3'd3, 2'b01, 64'h0123_4567_FFFF_FFFF, 64'h0, OKAY);
    drain();

    // INCR wrap at top of memory, then FIXED burst
    do_write(4'h3, 32'h1FF0, 8'd3, 3'd3, 2'b01, 4, 3, 64'hA1, 64'h1, 8'hFF, OKAY);
    drain();
    do_read(4'h3, 32'h1FF0, 8'd3, 3'd3, 2'b01, 64'hA1, 64'h1, OKAY);
    do_read(4'h4, 32'h0, 8'd1, 3'd3, 2'b01, 64'hA3, 64'h1, OKAY);
    drain();
    do_write(4'h6, 32'h300, 8'd3, 3'd3, 2'b00, 4, 3, 64'hB1, 64'h1, 8'hFF, OKAY);
    drain();
    do_read(4'h6, 32'h300, 8'd2, 3'd3, 2'b00, 64'hB4, 64'h0, OKAY);
    drain();

    // Address and size/burst errors
    do_write(4'h7, 32'h0001_0000, 8'd0, 3'd3, 2'b01, 1, 0, 64'hDEAD, 64'h0, 8'hFF, DECERR);
    drain();
    do_read(4'h7, 32'h0, 8'd0, 3'd3, 2'b01, 64'hA3, 64'h0, OKAY);
    do_read(4'h8, 32'h0001_0000, 8'd3, 3'd3, 2'b01, 64'h0, 64'h0, DECERR);
    do_write(4'h9, 32'h100, 8'd0, 3'd2, 2'b01, 1, 0, 64'hBAD, 64'h0, 8'hFF, SLVERR);
    drain();
    do_read(4'h9, 32'h100, 8'd0, 3'd3, 2'b01, 64'h11, 64'h0, OKAY);
    do_read(4'hA, 32'h100, 8'd0, 3'd3, 2'b10, 64'h0, 64'h0, SLVERR);
    drain();

    // w_last early, then w_last missing, then a normal burst
    do_write(4'hB, 32'h400, 8'd3, 3'd3, 2'b01, 2, 1, 64'hC1, 64'h1, 8'hFF, SLVERR);
    do_write(4'hC, 32'h400, 8'd1, 3'd3, 2'b01, 2, -1, 64'hC5, 64'h1, 8'hFF, SLVERR);
    do_write(4'hD, 32'h408, 8'd0, 3'd3, 2'b01, 1, 0, 64'hCC, 64'h0, 8'hFF, OKAY);
    drain();
    do_read(4'hD, 32'h400, 8'd1, 3'd3, 2'b01, 64'hC5, 64'h7, OKAY);
    drain();

    // 256-beat write, then 256-beat read with r_ready toggling
    do_write(4'hE, 32'h800, 8'd255, 3'd3, 2'b01, 256, 255, 64'hD000_0000_0000_0000, 64'h1, 8'hFF, OKAY);
    drain();
    rr_toggle = 1'b1;
    do_read(4'hF, 32'h800, 8'd255, 3'd3, 2'b01, 64'hD000_0000_0000_0000, 64'h1, OKAY);
    drain();
    rr_toggle = 1'b0;

    // Reset in the middle of a read burst
    mon_en = 1'b0;
    rr_level = 1'b0;
    bus.ar_id = 4'h1; bus.ar_addr = 32'h800; bus.ar_len = 8'd255;
    bus.ar_size = 3'd3; bus.ar_brust = 2'b01; bus.ar_valid = 1'b1;
    wait_hs(2, "ar_rst");
    bus.ar_valid = 1'b0;
    n = 0;
    while (!bus.r_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_r_valid", DW'(bus.r_valid), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_r_valid", DW'(bus.r_valid), 0);
    chk("mid_rst_ar_ready", DW'(bus.ar_ready), 1);
    chk("mid_rst_r_last", DW'(bus.r_last), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rr_level = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    do_read(4'h2, 32'h100, 8'd0, 3'd3, 2'b01, 64'h11, 64'h0, OKAY);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_slave_ram.md
Name: axi_slave_ram

Overview:
- AXI4 slave (responder) backed by an on-chip register/BRAM array. It is the other end of the axi_master_write / axi_master_read pair.
- Lets axi_ctrl and the masters run against on-chip memory in place of the MIG DDR3 core, for bring-up, simulation, and small frame buffers.
- Independent write and read engines, each with one outstanding burst. INCR and FIXED bursts, full-width beats only.

Parameters:
- DATA_WIDTH, 64, AXI data width in bits; must be a power of 2 and at least 8.
- ADDR_WIDTH, 32, AXI byte-address width.
- ID_WIDTH, 4, AXI ID width.
- MEM_DEPTH_LOG2, 10, log2 of memory depth in DATA_WIDTH words (default 1024 words = 8 KB).

Ports:
- axi_clk  in  1  single clock for all logic
- axi_rst  in  1  asynchronous, active-high reset
- s_axi_aw_id  in  ID_WIDTH  write address ID
- s_axi_aw_addr  in  ADDR_WIDTH  write byte address
- s_axi_aw_len  in  8  beats minus 1
- s_axi_aw_size  in  3  bytes per beat (log2)
- s_axi_aw_brust  in  2  burst type
- s_axi_aw_valid  in  1 / s_axi_aw_ready  out  1
- s_axi_w_data  in  DATA_WIDTH / s_axi_w_strb  in  DATA_WIDTH/8 / s_axi_w_last  in  1 / s_axi_w_valid  in  1 / s_axi_w_ready  out  1
- s_axi_b_id  out  ID_WIDTH / s_axi_b_resp  out  2 / s_axi_b_valid  out  1 / s_axi_b_ready  in  1
- s_axi_ar_id  in  ID_WIDTH / s_axi_ar_addr  in  ADDR_WIDTH / s_axi_ar_len  in  8 / s_axi_ar_size  in  3 / s_axi_ar_brust  in  2 / s_axi_ar_valid  in  1 / s_axi_ar_ready  out  1
- s_axi_r_id  out  ID_WIDTH / s_axi_r_data  out  DATA_WIDTH / s_axi_r_resp  out  2 / s_axi_r_last  out  1 / s_axi_r_valid  out  1 / s_axi_r_ready  in  1

Behaviour:
- Reset state: aw_ready=1 and ar_ready=1; w_ready, b_valid, r_valid and r_last=0; b_id, b_resp, r_id, r_resp and r_data=0. Both FSMs return to IDLE. Memory contents are not cleared. Reset mid-burst abandons the burst with no response.
- Word index = addr[LSB +: MEM_DEPTH_LOG2], where LSB = log2(DATA_WIDTH/8). Low LSB address bits are ignored.
- Error classification, latched at the address handshake:
  - Any address bit above LSB+MEM_DEPTH_LOG2 set → DECERR (2'b11).
  - Otherwise brust not in {FIXED 2'b00, INCR 2'b01}, or size != LSB → SLVERR (2'b10).
  - Otherwise OKAY.
  - On any error: writes suppressed, read data forced to 0, same error on every beat.
- Address advance:
  - INCR: index+1 per beat, wrapping modulo 2^MEM_DEPTH_LOG2 (no 4 KB boundary check).
  - FIXED: index held for the whole burst.
- Write FSM, W_IDLE → W_DATA → W_RESP:
  - W_IDLE: aw_ready=1. On aw_valid&aw_ready, latch id, index, len and err; aw_ready=0 and w_ready=1 from the next cycle.
  - W_DATA: each w_valid&w_ready beat writes the bytes whose strb bits are 1; bytes with strb=0 are unchanged. A beat counter runs 0..len.
  - Burst ends on the beat where counter==len OR w_last=1, whichever comes first.
  - w_last absent on the counted final beat, or present early → b_resp SLVERR, unless an error is already latched (DECERR takes precedence).
  - On the final beat: w_ready=0 next cycle, and b_valid=1 with b_id=latched id.
  - W_RESP: hold b_valid, b_id and b_resp stable until b_ready. Then W_IDLE with aw_ready=1 the next cycle.
  - Write handshake to b_valid latency: 1 cycle after the last W beat.
- Read FSM, R_IDLE → R_DATA:
  - R_IDLE: ar_ready=1. On handshake, latch the request and register mem[index] into r_data. r_valid=1 on the next cycle, with r_id=latched id and r_last=(len==0).
  - R_DATA: on r_valid&r_ready with more beats left, load the next word into r_data on the same edge, so back-to-back beats have no bubble.
  - With r_ready=0, hold r_data, r_last and r_resp stable.
  - After the beat with r_last=1 completes: r_valid=0 and R_IDLE, with ar_ready=1 the next cycle.
- Write and read engines run concurrently. Same-index read and write in the same cycle: the read returns the pre-write (old) data.
- len=255 (256 beats) is supported. The beat counter is 8 bits with no overflow at 255.

Optional Feature:
- AXI_SLV_BP_EN.
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every cycle.
  - w_ready is gated low when lfsr[0]=1.
  - A new r_valid beat (first or next) is withheld when lfsr[1]=1. Once asserted, r_valid is not withdrawn until accepted.
  - Handshake rules above otherwise unchanged.
- Undefined: w_ready is always high in W_DATA and r_valid has no extra gaps. The LFSR is not present.

Test Plan:
- INCR write, addr 0x0000_0100, len 3, data 0x11..0x44 full strb; then read the same → r beats 0x11, 0x22, 0x33, 0x44, r_last on beat 4, both resp OKAY, b_id=r_id=AW/AR id 4'h5.
- Write len 0, strb 8'h0F, data 0xFFFF_FFFF_FFFF_FFFF over word 0x0123_4567_89AB_CDEF → readback 0x0123_4567_FFFF_FFFF.
- INCR write at word 1022, len 3 (depth 1024) → words 1022, 1023, 0, 1 written; FIXED write len 3 → only the last beat's data remains at the index.
- Write addr 0x0001_0000 → b_resp=DECERR, memory unchanged. Read same → 4 beats of 0 with r_resp=DECERR. aw_size=2 → SLVERR.
- w_last on beat 2 of len 3 → burst ends, b_resp=SLVERR. Next AW accepted normally.
- Read len 255 with r_ready toggling 1/0 each cycle → 256 beats, data stable while stalled, r_last only on beat 256. Assert axi_rst mid-burst → r_valid=0 and ar_ready=1 on the following edge.
